// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, the request record and FSM states.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int SEL_W  = 4;

   typedef enum logic [SEL_W-1:0] {
      ADD  = 4'b0000,
      SUB  = 4'b0001,
      MUL  = 4'b0010,
      DIV  = 4'b0011,
      SHL  = 4'b0100,
      SHR  = 4'b0101,
      ROL  = 4'b0110,
      ROR  = 4'b0111,
      AND  = 4'b1000,
      OR   = 4'b1001,
      XOR  = 4'b1010,
      NOR  = 4'b1011,
      NAND = 4'b1100,
      XNOR = 4'b1101,
      GT   = 4'b1110,
      EQ   = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [SEL_W-1:0]  sel;
   } alu_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } issue_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; head entry is visible combinationally on rdata.
module alu_req_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  alu_req_t wdata,
   input  logic     pop,
   output alu_req_t rdata,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   alu_req_t    mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage wrapping a combinational ALU: buffers requests, drives the ALU pins,
// captures the result after one settle cycle and returns it over valid/ready.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | nothing in flight; pop the FIFO head as soon as it is non-empty
//   ST_DRIVE | alu_* driven with the popped request; ALU output settling
//   ST_RESP  | result held on rsp_* with rsp_valid high until rsp_ready
module alu_issue_ctrl #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [SEL_W-1:0]  req_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic [SEL_W-1:0]  rsp_sel,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   import alu_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   alu_req_t     push_data;
   alu_req_t     head;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;
   issue_state_e state;
   issue_state_e state_nxt;

   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign push_data = {req_a, req_b, req_sel};

   alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: state_nxt = ST_RESP;
         ST_RESP: begin
            // Back-to-back: the handshake cycle also launches the next request.
            if (rsp_ready) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = ST_DRIVE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_sel   <= '0;
         op_count  <= '0;
      end else begin
         if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
         end
         if (state == ST_DRIVE) begin
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_sel   <= alu_sel;
            rsp_valid <= 1'b1;
         end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_ONE;
         end
      end
   end

   assign busy = !empty || (state != ST_IDLE);

endmodule
